// File: rtl/divider_pkg.sv
// Shared types and sizing for the sequential signed divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_pkg;

  // Default operand width; the divider top takes its WIDTH default from here.
  localparam int DIV_WIDTH = 8;

  // Iteration counter width: counts 0..DIV_WIDTH-1 during DIV.
  localparam int CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for restoring division: computes a - b as a + ~b + 1 with a ripple carry chain.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module div_trial_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-2:0] diff,   // low N-1 bits of a - b
  output logic         sign    // top bit of a - b; 1 means b did not fit into a
);

  logic [N-1:0] sum;

  // Ripple-carry add of a and the inverted b, carry-in 1 supplies the +1 of the negate.
  always_comb begin
    logic carry;
    logic nb;
    sum   = '0;
    carry = 1'b1;
    nb    = 1'b0;
    for (int i = 0; i < N; i++) begin
      nb     = ~b[i];
      sum[i] = a[i] ^ nb ^ carry;
      carry  = (a[i] & nb) | (carry & (a[i] ^ nb));
    end
  end

  assign diff = sum[N-2:0];
  assign sign = sum[N-1];

endmodule

// File: rtl/signed_divider.sv
// Signed WIDTH-bit restoring divider, truncating toward zero, remainder signed like the dividend.
// Latency: Run sampled at edge k -> Done in cycle k+WIDTH+2; divide-by-zero -> Done in cycle k+2.
// Backpressure: Run ignored while Busy; Done held until Run drops, so a held Run gives one operation.
module signed_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic             Overflow
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;          // partial remainder
  logic [WIDTH-1:0] qs_q, qs_d;        // |dividend| shifting out, quotient bits shifting in
  logic [WIDTH-1:0] d_q, d_d;          // |divisor|
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_dvd_q, sign_dvd_d;
  logic             sign_dvs_q, sign_dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div_zero_q, div_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_neg;

  // Shift the next dividend bit into the remainder and try subtracting the divisor.
  assign trial_a = {r_q, qs_q[WIDTH-1]};
  assign trial_b = {1'b0, d_q};

  div_trial_sub #(.N(WIDTH + 1)) u_trial (
    .a    (trial_a),
    .b    (trial_b),
    .diff (trial_diff),
    .sign (trial_neg)
  );

  // State and datapath registers; Reset clears everything, including mid-division.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      r_q        <= '0;
      qs_q       <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      sign_dvd_q <= 1'b0;
      sign_dvs_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      qs_q       <= qs_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      sign_dvd_q <= sign_dvd_d;
      sign_dvs_q <= sign_dvs_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state and datapath update for LOAD / DIV / FIX / DONE sequencing.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    qs_d       = qs_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    sign_dvd_d = sign_dvd_q;
    sign_dvs_d = sign_dvs_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (Run) state_d = LOAD;
      end

      LOAD: begin
        // |0x80| stays 0x80 and is treated as unsigned 128 by the datapath.
        sign_dvd_d = Dividend[WIDTH-1];
        sign_dvs_d = Divisor[WIDTH-1];
        qs_d       = Dividend[WIDTH-1] ? (~Dividend + 1'b1) : Dividend;
        d_d        = Divisor[WIDTH-1]  ? (~Divisor + 1'b1)  : Divisor;
        r_d        = '0;
        cnt_d      = '0;
        div_zero_d = 1'b0;
        overflow_d = 1'b0;
        // A zero divisor skips the iterations; FIX writes the sentinel results.
        state_d    = (Divisor == '0) ? FIX : DIV;
      end

      DIV: begin
        if (!trial_neg) begin
          r_d  = trial_diff;
          qs_d = {qs_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d  = trial_a[WIDTH-1:0];
          qs_d = {qs_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end

      FIX: begin
        if (d_q == '0) begin
          // qs still holds |dividend|; restoring its sign returns the dividend unchanged.
          quot_d     = '1;
          rem_d      = sign_dvd_q ? -qs_q : qs_q;
          div_zero_d = 1'b1;
        end else begin
          quot_d     = (sign_dvd_q ^ sign_dvs_q) ? -qs_q : qs_q;
          rem_d      = sign_dvd_q ? -r_q : r_q;
          // Only most-negative / -1 yields magnitude 2^(WIDTH-1) with a positive sign.
          overflow_d = sign_dvd_q & sign_dvs_q & (qs_q == {1'b1, {(WIDTH-1){1'b0}}});
        end
        state_d = DONE;
      end

      DONE: begin
        if (!Run) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign Div_Zero  = div_zero_q;
  assign Overflow  = overflow_q;
  assign Busy      = (state_q == LOAD) || (state_q == DIV) || (state_q == FIX);
  assign Done      = (state_q == DONE);

endmodule
